// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, error codes, FSM states and request record for the RAM access sequencer.
package mem_ctrl_pkg;

   localparam logic [5:0] LD_W    = 6'b000000;
   localparam logic [5:0] LD_UB   = 6'b000001;
   localparam logic [5:0] LD_UH   = 6'b000010;
   localparam logic [5:0] LDD     = 6'b000011;
   localparam logic [5:0] ST_W    = 6'b000100;
   localparam logic [5:0] ST_B    = 6'b000101;
   localparam logic [5:0] ST_H    = 6'b000110;
   localparam logic [5:0] STD     = 6'b000111;
   localparam logic [5:0] LD_SB   = 6'b001001;
   localparam logic [5:0] LD_SH   = 6'b001010;
   localparam logic [5:0] MEM_NOP = 6'b111111;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_MSET  = 2'b01;
   localparam logic [1:0] ERR_TOUT  = 2'b10;
   localparam logic [1:0] ERR_ALIGN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ISSUE, S_SETTLE, S_WAIT, S_NEXT, S_DONE
   } state_e;

   typedef struct packed {
      logic        is_if;
      logic [5:0]  op;
      logic [31:0] addr;
      logic [63:0] wdata;
   } mem_req_t;

   // Alignment rule keyed on access size; byte accesses never fault.
   function automatic logic misaligned(input logic [5:0] op, input logic [2:0] a);
      logic m;
      m = 1'b0;
      case (op)
         LD_W, ST_W:          m = (a[1:0] != 2'b00);
         LDD, STD:            m = (a != 3'b000);
         LD_UH, ST_H, LD_SH:  m = a[0];
         default:             m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester arbiter: on contention the port not served last wins.
module mem_arb_rr2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req_if,
   input  logic req_d,
   input  logic done_stb,
   input  logic served_if,
   output logic gnt_if,
   output logic gnt_d
);

   // Starts as "fetch served last" so the data port wins the first tie.
   logic last_if;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        last_if <= 1'b1;
      else if (done_stb) last_if <= served_if;
   end

   always_comb begin
      gnt_d  = req_d & (~req_if | last_if);
      gnt_if = req_if & ~gnt_d;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter between fetch and data ports and the toggle-enabled RAM;
// doublewords are split into two word accesses.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15,
   parameter int TO_W        = 4
) (
   input  logic        Clk,
   input  logic        Clr_n,
   input  logic        If_Req,
   input  logic [31:0] If_Addr,
   output logic [31:0] If_Data,
   output logic        If_Done,
   output logic        If_Err,
   input  logic        D_Req,
   input  logic [5:0]  D_Op,
   input  logic [31:0] D_Addr,
   input  logic [63:0] D_WData,
   output logic [63:0] D_RData,
   output logic        D_Done,
   output logic        D_Err,
   output logic [1:0]  D_ErrCode,
   output logic        Mem_Enable,
   output logic [5:0]  Mem_OpCode,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_DataIn,
   input  logic [31:0] Mem_DataOut,
   input  logic        Mem_MFC,
   input  logic        Mem_MSET
);

   state_e            state, state_nx;
   mem_req_t          req;
   logic [5:0]        acc_op;
   logic              phase;
   logic [1:0]        err_code;
   logic [TO_W-1:0]   to_cnt;
   logic              gnt_if, gnt_d;
   logic              dbl, in_done, tout;

   assign dbl     = (req.op == LDD) || (req.op == STD);
   assign in_done = (state == S_DONE);
   assign tout    = (to_cnt == TO_W'(TIMEOUT_CYC));

   mem_arb_rr2 u_arb (
      .clk       (Clk),
      .rst_n     (Clr_n),
      .req_if    (If_Req),
      .req_d     (D_Req),
      .done_stb  (in_done),
      .served_if (req.is_if),
      .gnt_if    (gnt_if),
      .gnt_d     (gnt_d)
   );

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (gnt_if | gnt_d) state_nx = S_CHECK;
         S_CHECK:  state_nx = misaligned(req.op, req.addr[2:0]) ? S_DONE : S_ISSUE;
         S_ISSUE:  state_nx = S_SETTLE;
         S_SETTLE: state_nx = S_WAIT;
         S_WAIT: begin
            if (Mem_MSET)     state_nx = S_DONE;
            else if (Mem_MFC) state_nx = S_NEXT;
            else if (tout)    state_nx = S_DONE;
         end
         S_NEXT:   state_nx = (dbl && !phase) ? S_ISSUE : S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         req        <= '0;
         acc_op     <= LD_W;
         phase      <= 1'b0;
         err_code   <= ERR_NONE;
         to_cnt     <= '0;
         Mem_Enable <= 1'b0;
         Mem_OpCode <= MEM_NOP;
         Mem_Addr   <= '0;
         Mem_DataIn <= '0;
         If_Data    <= '0;
         D_RData    <= '0;
      end else begin
         case (state)
            S_IDLE: if (gnt_if | gnt_d) begin
               req.is_if <= gnt_if;
               req.op    <= gnt_if ? LD_W : D_Op;
               req.addr  <= gnt_if ? If_Addr : D_Addr;
               req.wdata <= D_WData;
               err_code  <= ERR_NONE;
               phase     <= 1'b0;
            end
            S_CHECK: begin
               if (misaligned(req.op, req.addr[2:0])) err_code <= ERR_ALIGN;
               acc_op <= (req.op == LDD) ? LD_W : (req.op == STD) ? ST_W : req.op;
            end
            S_ISSUE: begin
               Mem_OpCode <= acc_op;
               Mem_Addr   <= req.addr;
               Mem_DataIn <= (req.op == STD && !phase) ? req.wdata[63:32] : req.wdata[31:0];
               Mem_Enable <= ~Mem_Enable;
               to_cnt     <= '0;
            end
            // MSET wins over MFC; an error here also cancels any second phase.
            S_WAIT: begin
               if (Mem_MSET)             err_code <= ERR_MSET;
               else if (Mem_MFC) begin
                  if (req.is_if)         If_Data <= Mem_DataOut;
                  else if (dbl && !phase) D_RData[63:32] <= Mem_DataOut;
                  else                   D_RData[31:0]  <= Mem_DataOut;
               end
               else if (tout)            err_code <= ERR_TOUT;
               else                      to_cnt <= to_cnt + TO_W'(1);
            end
            S_NEXT: if (dbl && !phase) begin
               phase    <= 1'b1;
               req.addr <= req.addr + 32'd4;
            end
            default: ;
         endcase
         if (state_nx == S_DONE) Mem_OpCode <= MEM_NOP;
      end
   end

   always_comb begin
      If_Done   = in_done &  req.is_if;
      D_Done    = in_done & ~req.is_if;
      If_Err    = If_Done & (err_code != ERR_NONE);
      D_Err     = D_Done  & (err_code != ERR_NONE);
      D_ErrCode = D_Done ? err_code : ERR_NONE;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized checks of mem_access_ctrl against a behavioural RAM
// and a transaction-level expectation model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
   import mem_ctrl_pkg::*;

   localparam int TO = 15;

   logic        Clk = 1'b0, Clr_n = 1'b0;
   logic        If_Req = 1'b0, D_Req = 1'b0;
   logic [31:0] If_Addr = '0, D_Addr = '0;
   logic [5:0]  D_Op = '0;
   logic [63:0] D_WData = '0;
   logic [31:0] If_Data, Mem_Addr, Mem_DataIn, Mem_DataOut;
   logic [63:0] D_RData;
   logic        If_Done, If_Err, D_Done, D_Err, Mem_Enable, Mem_MFC, Mem_MSET;
   logic [1:0]  D_ErrCode;
   logic [5:0]  Mem_OpCode;

   always #5 Clk = ~Clk;

   mem_access_ctrl #(.TIMEOUT_CYC(TO), .TO_W(4)) dut (
      .Clk(Clk), .Clr_n(Clr_n),
      .If_Req(If_Req), .If_Addr(If_Addr), .If_Data(If_Data), .If_Done(If_Done), .If_Err(If_Err),
      .D_Req(D_Req), .D_Op(D_Op), .D_Addr(D_Addr), .D_WData(D_WData), .D_RData(D_RData),
      .D_Done(D_Done), .D_Err(D_Err), .D_ErrCode(D_ErrCode),
      .Mem_Enable(Mem_Enable), .Mem_OpCode(Mem_OpCode), .Mem_Addr(Mem_Addr),
      .Mem_DataIn(Mem_DataIn), .Mem_DataOut(Mem_DataOut), .Mem_MFC(Mem_MFC), .Mem_MSET(Mem_MSET)
   );

   int total = 0, bad = 0;

   typedef struct { logic [5:0] op; logic [31:0] addr; logic [31:0] din; } acc_t;
   acc_t        acc_q[$];
   logic [31:0] ram [logic [31:0]];
   int          ram_lat = 1;
   bit          ram_mset = 1'b0;
   logic [31:0] exp_ifdata = '0;
   logic [63:0] exp_rdata = '0;
   bit          model_last_if = 1'b1;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : ((a ^ 32'h5A5A_0000) * 32'd3 + 32'h0101_0101);
   endfunction

   function automatic int acc_bytes(input logic [5:0] op);
      case (op)
         LDD, STD:            return 8;
         LD_W, ST_W:          return 4;
         LD_UH, LD_SH, ST_H:  return 2;
         default:             return 1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // RAM: a level change on Mem_Enable starts an access; MFC/MSET keep their
   // old value until the edge that notices the change, then complete after ram_lat.
   logic en_q = 1'b0;
   bit   busy = 1'b0;
   int   c = 0;
   acc_t cur;
   initial begin
      Mem_MFC <= 1'b0; Mem_MSET <= 1'b0; Mem_DataOut <= '0;
      forever begin
         @(posedge Clk);
         if (Mem_Enable !== en_q) begin
            en_q = Mem_Enable;
            busy = (Mem_OpCode !== MEM_NOP);
            c = 1;
            cur.op = Mem_OpCode; cur.addr = Mem_Addr; cur.din = Mem_DataIn;
            Mem_MFC <= 1'b0; Mem_MSET <= 1'b0;
            if (busy) acc_q.push_back(cur);
         end else if (busy) c++;
         if (busy && ram_lat != 0 && c >= ram_lat) begin
            busy = 1'b0;
            if (ram_mset) begin
               Mem_MSET <= 1'b1; Mem_MFC <= 1'b1;
            end else begin
               if (cur.op inside {ST_W, ST_B, ST_H}) ram[cur.addr] = cur.din;
               Mem_DataOut <= rd(cur.addr);
               Mem_MFC <= 1'b1;
            end
         end
      end
   end

   // One request on one port, checked against the expected outcome, timing and RAM traffic.
   task automatic xact(input bit is_if, input logic [5:0] op_in, input logic [31:0] a,
                       input logic [63:0] wd, input int lat, input bit mset);
      logic [5:0] op; bit dbl, st, got; int cyc, exp_cyc;
      logic [1:0] code; logic [31:0] val, ei; logic [63:0] er; acc_t ex[$]; acc_t e;
      op = is_if ? LD_W : op_in;
      dbl = op inside {LDD, STD};
      st  = op inside {ST_W, ST_B, ST_H, STD};
      er = exp_rdata; ei = exp_ifdata; code = 2'd0; exp_cyc = 2;
      if ((int'(a[2:0]) % acc_bytes(op)) != 0) code = 2'd3;
      else for (int i = 0; i < (dbl ? 2 : 1); i++) begin
         e.op = dbl ? (st ? ST_W : LD_W) : op;
         e.addr = a + 32'(4 * i);
         e.din = (dbl && i == 0) ? wd[63:32] : wd[31:0];
         ex.push_back(e);
         if (mset) begin code = 2'd1; exp_cyc += 2 + lat; break; end
         if (lat == 0) begin code = 2'd2; exp_cyc += 3 + TO; break; end
         exp_cyc += 3 + lat;
         val = st ? e.din : rd(e.addr);
         if (is_if) ei = val;
         else if (dbl && i == 0) er[63:32] = val;
         else er[31:0] = val;
      end

      acc_q.delete(); ram_lat = lat; ram_mset = mset;
      @(negedge Clk);
      if (is_if) begin If_Addr = a; If_Req = 1'b1; end
      else begin D_Op = op; D_Addr = a; D_WData = wd; D_Req = 1'b1; end
      cyc = 0; got = 1'b0;
      while (!got && cyc < 300) begin
         @(negedge Clk); cyc++;
         got = is_if ? If_Done : D_Done;
         chk("other_done_quiet", is_if ? D_Done : If_Done, 1'b0);
      end
      chk("done_seen", got, 1'b1);
      chk("latency", cyc, exp_cyc);
      chk("err", is_if ? If_Err : D_Err, code != 2'd0);
      if (!is_if) chk("err_code", D_ErrCode, code);
      If_Req = 1'b0; D_Req = 1'b0;
      @(negedge Clk);
      chk("done_one_cycle", is_if ? If_Done : D_Done, 1'b0);
      chk("if_data", If_Data, ei);
      chk("d_rdata", D_RData, er);
      chk("acc_count", acc_q.size(), ex.size());
      for (int i = 0; i < ex.size() && i < acc_q.size(); i++) begin
         chk("acc_op", acc_q[i].op, ex[i].op);
         chk("acc_addr", acc_q[i].addr, ex[i].addr);
         if (st) chk("acc_din", acc_q[i].din, ex[i].din);
      end
      chk("opcode_idle", Mem_OpCode, MEM_NOP);
      exp_rdata = er; exp_ifdata = ei; model_last_if = is_if;
   endtask

   // Both ports request together; the one not served last must go first.
   task automatic dual(input logic [31:0] ia, input logic [31:0] da);
      bit order[$]; bit first_if; int cyc; logic [31:0] ei, ed;
      ei = rd(ia); ed = rd(da); first_if = !model_last_if;
      ram_lat = 1; ram_mset = 1'b0;
      @(negedge Clk);
      If_Addr = ia; D_Op = LD_W; D_Addr = da; If_Req = 1'b1; D_Req = 1'b1;
      cyc = 0;
      while (order.size() < 2 && cyc < 300) begin
         @(negedge Clk); cyc++;
         if (If_Done) begin order.push_back(1'b1); If_Req = 1'b0; end
         if (D_Done)  begin order.push_back(1'b0); D_Req = 1'b0; end
      end
      chk("arb_count", order.size(), 2);
      chk("arb_first", (order.size() > 0) ? int'(order[0]) : 2, first_if);
      chk("arb_second", (order.size() > 1) ? int'(order[1]) : 2, !first_if);
      If_Req = 1'b0; D_Req = 1'b0;
      @(negedge Clk);
      chk("arb_if_data", If_Data, ei);
      chk("arb_d_rdata", D_RData[31:0], ed);
      exp_ifdata = ei; exp_rdata[31:0] = ed; model_last_if = !first_if;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_if_done"}, If_Done, 1'b0);
      chk({tag, "_if_err"}, If_Err, 1'b0);
      chk({tag, "_d_done"}, D_Done, 1'b0);
      chk({tag, "_d_err"}, D_Err, 1'b0);
      chk({tag, "_d_errcode"}, D_ErrCode, 2'b00);
      chk({tag, "_if_data"}, If_Data, 32'h0);
      chk({tag, "_d_rdata"}, D_RData, 64'h0);
      chk({tag, "_mem_en"}, Mem_Enable, 1'b0);
      chk({tag, "_mem_op"}, Mem_OpCode, MEM_NOP);
      chk({tag, "_mem_addr"}, Mem_Addr, 32'h0);
      chk({tag, "_mem_din"}, Mem_DataIn, 32'h0);
   endtask

   logic [5:0] ops [10] = '{LD_W, LD_UB, LD_UH, LDD, ST_W, ST_B, ST_H, STD, LD_SB, LD_SH};

   initial begin
      repeat (3) @(negedge Clk);
      chk_reset_outputs("rst");
      Clr_n = 1'b1;
      repeat (2) @(negedge Clk);

      ram[32'h10] = 32'hDEADBEEF;
      xact(1'b1, LD_W, 32'h10, 64'h0, 2, 1'b0);
      xact(1'b0, STD, 32'h20, 64'h11223344_55667788, 1, 1'b0);
      xact(1'b0, LDD, 32'h20, 64'h0, 2, 1'b0);
      xact(1'b0, LDD, 32'h24, 64'h0, 1, 1'b0);
      xact(1'b0, ST_W, 32'h40, 64'h0_CAFEF00D, 1, 1'b1);
      xact(1'b0, STD, 32'h48, 64'hAAAA5555_12345678, 2, 1'b1);
      xact(1'b0, LD_W, 32'h44, 64'h0, 0, 1'b0);
      xact(1'b0, LD_SH, 32'h51, 64'h0, 1, 1'b0);
      xact(1'b0, ST_B, 32'h53, 64'h0_000000A5, 3, 1'b0);
      xact(1'b1, LD_W, 32'h62, 64'h0, 1, 1'b0);

      // Reset in the middle of a fetch that never completes.
      ram_lat = 0; ram_mset = 1'b0;
      @(negedge Clk); If_Addr = 32'h80; If_Req = 1'b1;
      repeat (6) @(negedge Clk);
      chk("inflight_op", Mem_OpCode, LD_W);
      #1 Clr_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      If_Req = 1'b0; exp_ifdata = '0; exp_rdata = '0; model_last_if = 1'b1;
      @(negedge Clk); Clr_n = 1'b1;
      repeat (2) @(negedge Clk);
      xact(1'b1, LD_W, 32'h84, 64'h0, 1, 1'b0);

      for (int k = 0; k < 3; k++) dual(32'h200 + 32'(16 * k), 32'h300 + 32'(16 * k));

      for (int k = 0; k < 30; k++) begin
         bit fi, ms; logic [5:0] op; logic [31:0] a; int lat;
         fi = ($urandom_range(0, 3) == 0);
         op = ops[$urandom_range(0, 9)];
         a = 32'h100 + 32'($urandom_range(0, 15)) * 32'd8
             + (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 7)) : 32'd0);
         lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
         ms = !fi && (op inside {ST_W, ST_B, ST_H, STD}) && lat != 0 && ($urandom_range(0, 4) == 0);
         xact(fi, op, a, {$urandom, $urandom}, lat, ms);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
